cart_bus_master: RTL

//  Drives the DMG cartridge-slot bus (A, D, nRD, nWR, nCS) from a simple request/response port.

---
 rtl/cart_bus_pkg.sv | 16 +
 rtl/cart_bus_if.sv | 34 +++
 rtl/cart_bus_decode.sv | 22 ++
 rtl/cart_bus_master.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/cart_bus_pkg.sv
// cart_bus_pkg: shared types and address-map constants for the DMG cartridge
// bus master (FSM states, address classes, region boundaries).
package cart_bus_pkg;

   typedef enum logic [2:0] {IDLE, T1, T2, T3, T4} state_t;

   typedef enum logic [1:0] {ROM, VWRAM, CRAM, INT} addr_class_t;

   localparam logic [15:0] CART_RAM_LO = 16'hA000;
   localparam logic [15:0] CART_RAM_HI = 16'hBFFF;
   localparam logic [15:0] INT_LO      = 16'hFE00;
   localparam logic [15:0] ROM_HI      = 16'h7FFF;

   localparam int unsigned WAIT_CNT_W  = 4;

endpackage

// File: rtl/cart_bus_if.sv
// cart_bus_if: request/response port plus cartridge-slot pins of the bus master.
//   Request side : req, ready, req_addr, req_we, req_wdata, rdata, rvalid, err
//   Cartridge side: a, d_out, d_oe, d_in, nrd, nwr, ncs, nwait
//   master modport: the bus master; slave modport: CPU + cartridge environment.
interface cart_bus_if;

   logic        req;
   logic        ready;
   logic [15:0] req_addr;
   logic        req_we;
   logic [7:0]  req_wdata;
   logic [7:0]  rdata;
   logic        rvalid;
   logic        err;
   logic [15:0] a;
   logic [7:0]  d_out;
   logic        d_oe;
   logic [7:0]  d_in;
   logic        nrd;
   logic        nwr;
   logic        ncs;
   logic        nwait;

   modport master (
      input  req, req_addr, req_we, req_wdata, d_in, nwait,
      output ready, rdata, rvalid, err, a, d_out, d_oe, nrd, nwr, ncs
   );

   modport slave (
      output req, req_addr, req_we, req_wdata, d_in, nwait,
      input  ready, rdata, rvalid, err, a, d_out, d_oe, nrd, nwr, ncs
   );

endinterface

// File: rtl/cart_bus_decode.sv
// cart_bus_decode: combinational address-class decode.
//   i_addr in  16  CPU address
//   o_cls  out  2  ROM (0000-7FFF), CRAM (A000-BFFF), INT (FE00-FFFF), VWRAM (rest)
module cart_bus_decode
   import cart_bus_pkg::*;
(
   input  logic [15:0] i_addr,
   output addr_class_t o_cls
);

   always_comb begin
      o_cls = VWRAM;
      if (i_addr <= ROM_HI) begin
         o_cls = ROM;
      end else if (i_addr >= CART_RAM_LO && i_addr <= CART_RAM_HI) begin
         o_cls = CRAM;
      end else if (i_addr >= INT_LO) begin
         o_cls = INT;
      end
   end

endmodule

// File: rtl/cart_bus_master.sv
// cart_bus_master: runs one 4-T-cycle DMG cartridge bus cycle per accepted request.
//   clk   in  T-cycle clock (rising edge)
//   nrst  in  asynchronous active-low reset
//   bus   cart_bus_if.master: request port (req/ready/req_*/rdata/rvalid/err)
//         and cartridge pins (a/d_out/d_oe/d_in/nrd/nwr/ncs/nwait)
// Optional feature macro: CART_BUS_WAIT_EN (nwait stretches T3 up to WAIT_MAX
// extra cycles; on expiry err pulses alongside the cycle's completion).
module cart_bus_master
   import cart_bus_pkg::*;
#(
   parameter int unsigned WAIT_MAX = 15
)
(
   input  logic       clk,
   input  logic       nrst,
   cart_bus_if.master bus
);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_addr;
   logic        r_we;
   logic [7:0]  r_wdata;
   addr_class_t r_cls;
   addr_class_t w_req_cls;
   logic [7:0]  r_rdata;
   logic        r_rvalid;
   logic        r_err;
   logic        w_ready;
   logic        w_accept;
   logic        w_t4_exit;
   logic        w_wait_hold;
   logic        w_timeout_exit;

   cart_bus_decode u_decode (
      .i_addr (bus.req_addr),
      .o_cls  (w_req_cls)
   );

   assign w_ready   = (r_state == IDLE) || (r_state == T4);
   assign w_accept  = bus.req && w_ready;
   assign w_t4_exit = (r_state == T4);

`ifdef CART_BUS_WAIT_EN
   localparam logic [WAIT_CNT_W-1:0] LP_WAIT_MAX = WAIT_CNT_W'(WAIT_MAX);

   logic [WAIT_CNT_W-1:0] r_wait_cnt;
   logic                  r_timeout;
   logic                  w_wait_expire;

   assign w_wait_hold   = (r_state == T3) && !bus.nwait && (r_wait_cnt != LP_WAIT_MAX);
   assign w_wait_expire = (r_state == T3) && !bus.nwait && (r_wait_cnt == LP_WAIT_MAX);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_wait_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         if (r_state == T2) begin
            r_wait_cnt <= '0;
         end else if (w_wait_hold) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
         // Timeout is remembered through T4 so err lines up with rvalid.
         if (w_wait_expire) begin
            r_timeout <= 1'b1;
         end else if (w_t4_exit) begin
            r_timeout <= 1'b0;
         end
      end
   end

   assign w_timeout_exit = w_t4_exit && r_timeout;
`else
   logic w_unused_nwait;

   assign w_unused_nwait = bus.nwait;
   assign w_wait_hold    = 1'b0;
   assign w_timeout_exit = 1'b0;
`endif

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = T1;
         T1:      w_state_nxt = T2;
         T2:      w_state_nxt = T3;
         T3:      if (!w_wait_hold) w_state_nxt = T4;
         T4:      w_state_nxt = w_accept ? T1 : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_wdata <= '0;
         r_cls   <= ROM;
      end else if (w_accept) begin
         r_addr  <= bus.req_addr;
         r_we    <= bus.req_we;
         r_wdata <= bus.req_wdata;
         r_cls   <= w_req_cls;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_rvalid <= w_t4_exit && !r_we;
         r_err    <= w_timeout_exit;
         if (w_t4_exit && !r_we) begin
            r_rdata <= (r_cls == INT) ? 8'hFF : bus.d_in;
         end
      end
   end

   // Strobes decode straight from the state register so an async reset
   // releases them in the same instant as the state returns to IDLE.
   always_comb begin
      logic w_ext;
      logic w_mid;
      w_ext      = (r_cls != INT);
      w_mid      = (r_state == T2) || (r_state == T3) || (r_state == T4);
      bus.ready  = w_ready;
      bus.a      = r_addr;
      bus.d_out  = r_wdata;
      bus.d_oe   = w_mid && r_we && w_ext;
      bus.nrd    = !((r_state != IDLE) && !r_we && w_ext);
      bus.nwr    = !((r_state == T3) && r_we && w_ext);
      bus.ncs    = !(w_mid && (r_cls == CRAM));
      bus.rdata  = r_rdata;
      bus.rvalid = r_rvalid;
      bus.err    = r_err;
   end

endmodule
